param_alu_hs: RTL and testbench



---
 rtl/param_alu_hs.sv | 178 +++++++++++++++++
 tb/tb_param_alu_hs.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_alu_hs.sv
// Handshaked WIDTH-bit ALU with programmable EXEC latency and Z/N/C/illegal flags.
// Optional shift-add multiplier enabled by defining ALU_MUL_EN.
module param_alu_hs #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 3,
    localparam int unsigned SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_bus,
    input  logic [WIDTH-1:0] b_bus,
    input  logic [3:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_bus,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic             illegal_op
);

    localparam int unsigned CW = 6;

    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpSub   = 4'b0010;
    localparam logic [3:0] OpPassA = 4'b0011;
    localparam logic [3:0] OpPassB = 4'b0100;
    localparam logic [3:0] OpInc   = 4'b0101;
    localparam logic [3:0] OpDec   = 4'b0110;
    localparam logic [3:0] OpShl1  = 4'b0111;
    localparam logic [3:0] OpShl2  = 4'b1000;
    localparam logic [3:0] OpShl8  = 4'b1001;
    localparam logic [3:0] OpShr4  = 4'b1010;
    localparam logic [3:0] OpClr   = 4'b1011;
    localparam logic [3:0] OpMul   = 4'b1100;
    localparam logic [3:0] OpShlv  = 4'b1101;
    localparam logic [3:0] OpShrv  = 4'b1110;

    localparam logic [WIDTH:0] One = (WIDTH+1)'(1);

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_load;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic [SHW-1:0]   sh_q;

    logic [WIDTH-1:0] c_bus_q;
    logic             z_q, n_q, c_q, ill_q;

    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ill;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;

    // One multiplier bit per EXEC cycle; acc_d already includes the current bit.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StHold);
    assign c_bus      = c_bus_q;
    assign z_flag     = z_q;
    assign n_flag     = n_q;
    assign c_flag     = c_q;
    assign illegal_op = ill_q;

    always_comb begin
`ifdef ALU_MUL_EN
        cnt_load = (op == OpMul) ? CW'(WIDTH - 1) : CW'(LATENCY - 1);
`else
        cnt_load = CW'(LATENCY - 1);
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StExec;
            StExec:  if (cnt_q == '0) state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shifts run on a one-bit-extended operand so the extra bit is the carry.
    always_comb begin
        res  = '0;
        cout = 1'b0;
        ill  = 1'b0;
        case (op_q)
            OpAdd:   {cout, res} = {1'b0, a_q} + {1'b0, b_q};
            OpSub:   {cout, res} = {1'b0, a_q} - {1'b0, b_q};
            OpPassA: res = a_q;
            OpPassB: res = b_q;
            OpInc:   {cout, res} = {1'b0, a_q} + One;
            OpDec:   {cout, res} = {1'b0, a_q} - One;
            OpShl1:  {cout, res} = {1'b0, a_q} << 1;
            OpShl2:  {cout, res} = {1'b0, a_q} << 2;
            OpShl8:  {cout, res} = {1'b0, a_q} << 8;
            OpShr4:  {res, cout} = {a_q, 1'b0} >> 4;
            OpClr:   res = '0;
            OpShlv:  {cout, res} = {1'b0, a_q} << sh_q;
            OpShrv:  {res, cout} = {a_q, 1'b0} >> sh_q;
`ifdef ALU_MUL_EN
            OpMul: begin
                res  = acc_d[WIDTH-1:0];
                cout = |acc_d[2*WIDTH-1:WIDTH];
            end
`endif
            default: ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sh_q     <= '0;
            c_bus_q  <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a_bus;
                        b_q      <= b_bus;
                        op_q     <= op;
                        sh_q     <= shamt;
                        cnt_q    <= cnt_load;
`ifdef ALU_MUL_EN
                        mcand_q  <= {{WIDTH{1'b0}}, a_bus};
                        acc_q    <= '0;
                        mplier_q <= b_bus;
`endif
                    end
                end
                StExec: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        c_bus_q <= res;
                        z_q     <= (res == '0);
                        n_q     <= res[WIDTH-1];
                        c_q     <= cout;
                        ill_q   <= ill;
                    end
`ifdef ALU_MUL_EN
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu_hs.sv
// Self-checking bench for param_alu_hs (WIDTH=16, LATENCY=3): directed cases from the
// datasheet plus randomized ops against an arithmetic reference model.
module tb_param_alu_hs;

    localparam int W = 16;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_bus = '0;
    logic [15:0] b_bus = '0;
    logic [3:0]  op = '0;
    logic [3:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] c_bus;
    logic        z_flag, n_flag, c_flag, illegal_op;

    int checks = 0;
    int failures = 0;

    param_alu_hs #(.WIDTH(W), .LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .op        (op),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_bus     (c_bus),
        .z_flag    (z_flag),
        .n_flag    (n_flag),
        .c_flag    (c_flag),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {illegal, carry, result} from the opcode table using plain integer arithmetic.
    function automatic logic [17:0] model(input logic [3:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] sh);
        longint ai = longint'(a);
        longint bi = longint'(b);
        longint r = 0;
        longint c = 0;
        logic   il = 1'b0;
        int     k;
        case (o)
            4'd1: begin r = ai + bi; c = (r > 65535) ? 1 : 0; end
            4'd2: begin r = ai - bi + 65536; c = (ai < bi) ? 1 : 0; end
            4'd3: r = ai;
            4'd4: r = bi;
            4'd5: begin r = ai + 1; c = (ai == 65535) ? 1 : 0; end
            4'd6: begin r = ai + 65535; c = (ai == 0) ? 1 : 0; end
            4'd7, 4'd8, 4'd9: begin
                k = (o == 4'd7) ? 1 : (o == 4'd8) ? 2 : 8;
                r = ai * (longint'(1) << k);
                c = (ai / (longint'(1) << (16 - k))) % 2;
            end
            4'd10: begin r = ai / 16; c = (ai / 8) % 2; end
            4'd11: r = 0;
            4'd13: begin
                r = ai * (longint'(1) << sh);
                c = (sh == 0) ? 0 : (ai / (longint'(1) << (16 - sh))) % 2;
            end
            4'd14: begin
                r = ai / (longint'(1) << sh);
                c = (sh == 0) ? 0 : (ai / (longint'(1) << (sh - 1))) % 2;
            end
`ifdef ALU_MUL_EN
            4'd12: begin r = ai * bi; c = (r >= 65536) ? 1 : 0; end
`endif
            default: il = 1'b1;
        endcase
        r = r % 65536;
        return {il, c[0], r[15:0]};
    endfunction

    function automatic int exp_latency(input logic [3:0] o);
`ifdef ALU_MUL_EN
        if (o == 4'd12) return W;
`endif
        return L;
    endfunction

    // Issues one op from IDLE, checks timing/results, holds for `hold` cycles, then consumes.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sh, input int hold);
        logic [17:0] m;
        logic [15:0] er;
        int n;
        m  = model(o, a, b, sh);
        er = m[15:0];
        chk({tag, ".in_ready"}, in_ready, 1);
        a_bus = a; b_bus = b; op = o; shamt = sh; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a_bus = 16'($urandom);
        b_bus = 16'($urandom);
        shamt = 4'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, n, exp_latency(o));
        chk({tag, ".c_bus"}, c_bus, er);
        chk({tag, ".z"}, z_flag, (er == 16'h0));
        chk({tag, ".n"}, n_flag, er[15]);
        chk({tag, ".c"}, c_flag, m[16]);
        chk({tag, ".illegal"}, illegal_op, m[17]);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_ready"}, in_ready, 0);
            chk({tag, ".hold_c_bus"}, {c_flag, c_bus}, {m[16], er});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".exit_valid"}, out_valid, 0);
        chk({tag, ".exit_ready"}, in_ready, 1);
        chk({tag, ".retain"}, c_bus, er);
    endtask

    initial begin
        int n;
        int last;
        int accepts;
        logic seen;
        logic [3:0] ro;

        // Reset state
        tick();
        tick();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.outputs", {c_bus, z_flag, n_flag, c_flag, illegal_op}, 0);
        rst_n = 1'b1;
        tick();

        do_op("add_wrap", 4'd1, 16'hFFFF, 16'h0001, 4'd0, 0);
        do_op("sub_neg", 4'd2, 16'h0003, 16'h0005, 4'd0, 5);
        do_op("shlv1", 4'd13, 16'h8001, 16'h0000, 4'd1, 0);
        do_op("shrv15", 4'd14, 16'h8001, 16'h0000, 4'd15, 0);
        do_op("shl8", 4'd9, 16'h12F4, 16'h0000, 4'd0, 0);
        do_op("mul", 4'd12, 16'h0012, 16'h0010, 4'd0, 1);
        do_op("illegal0", 4'd0, 16'h1234, 16'h5678, 4'd0, 0);
        do_op("illegal15", 4'd15, 16'h1234, 16'h5678, 4'd0, 0);
        do_op("dec_zero", 4'd6, 16'h0000, 16'h0000, 4'd0, 0);

        // Reset while in HOLD
        a_bus = 16'h7000; b_bus = 16'h1000; op = 4'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("hold_rst.reached", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("hold_rst.out_valid", out_valid, 0);
        chk("hold_rst.in_ready", in_ready, 1);
        chk("hold_rst.outputs", {c_bus, z_flag, n_flag, c_flag, illegal_op}, 0);

        // Reset mid-EXEC discards the op
        a_bus = 16'h0001; op = 4'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < L + 3; i++) begin
            seen = seen | out_valid;
            tick();
        end
        chk("exec_rst.no_output", seen, 0);
        chk("exec_rst.c_bus", c_bus, 0);

        // Back-to-back: one accept per LATENCY+2 cycles
        a_bus = 16'h0101; b_bus = 16'h0202; op = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
        last = -1;
        accepts = 0;
        for (int i = 0; i < 5 * (L + 2); i++) begin
            if (in_ready) begin
                if (last >= 0) chk("b2b.gap", i - last, L + 2);
                last = i;
                accepts++;
            end
            tick();
        end
        chk("b2b.accepts", accepts, 5);
        chk("b2b.result", c_bus, 16'h0303);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("b2b.drain", in_ready, 1);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            do_op("rand", ro, 16'($urandom), 16'($urandom), 4'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
